bcd_to_bin: RTL

- Sequential BCD-to-binary converter: the inverse of the display-path binary-to-BCD conversion.
- Accepts four BCD digits, for example a value keyed in or read back from the SSD digit registers, and produces the binary value.
- Uses an iterative reverse double-dabble loop: one bit per clock, shift right, then subtract 3 from each digit that is 8 or more.
- Sits between digit-entry or memory-mapped I/O logic and the datapath; start/valid handshake.

---
 rtl/bcd_to_bin.sv | 101 ++++++++++
 1 files changed

// File: rtl/bcd_to_bin.sv
// Sequential four-digit BCD to binary converter (reverse double-dabble, one bit per clock).
// start/valid handshake; digit and range errors are reported alongside valid.
module bcd_to_bin #(
    parameter int BIN_W = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       th_in,
    input  logic [3:0]       hundreds_in,
    input  logic [3:0]       tens_in,
    input  logic [3:0]       ones_in,
    output logic [BIN_W-1:0] bin,
    output logic             valid,
    output logic             busy,
    output logic             err_digit,
    output logic             err_range
);

    localparam int WORK_W = 16 + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]        state;
    logic [WORK_W-1:0] work;
    logic [WORK_W-1:0] shifted;
    logic [WORK_W-1:0] adjusted;
    logic [CNT_W-1:0]  cnt;
    logic              digit_bad;

    assign digit_bad = (th_in > 4'd9) || (hundreds_in > 4'd9) ||
                       (tens_in > 4'd9) || (ones_in > 4'd9);

    // A BCD field reaching 8 after the shift received a bit worth ten from above; halved is 5, so take 3 off.
    always_comb begin
        shifted  = work >> 1;
        adjusted = shifted;
        for (int unsigned i = 0; i < 4; i++) begin
            if (shifted[BIN_W + 4*i +: 4] >= 4'd8)
                adjusted[BIN_W + 4*i +: 4] = shifted[BIN_W + 4*i +: 4] - 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= '0;
            cnt       <= '0;
            bin       <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            err_digit <= 1'b0;
            err_range <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (digit_bad) begin
                            err_digit <= 1'b1;
                            err_range <= 1'b0;
                            bin       <= '0;
                            valid     <= 1'b1;
                            state     <= DONE;
                        end else begin
                            work  <= {th_in, hundreds_in, tens_in, ones_in, {BIN_W{1'b0}}};
                            cnt   <= '0;
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work <= adjusted;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(BIN_W - 1)) begin
                        bin       <= adjusted[BIN_W-1:0];
                        err_range <= |adjusted[WORK_W-1:BIN_W];
                        err_digit <= 1'b0;
                        valid     <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
